// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment scanner.
// Segment drive is active-low, so SEG_OFF turns every segment and the dp dark.
package seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } seg_state_t;

  localparam logic [7:0] SEG_OFF = 8'hFF;

endpackage : seg_pkg

// File: rtl/seg_scan.sv
// Time-multiplexed scanner for DIGITS common-anode digits, one slot of DIV clocks per digit.
// Define SEG_SCAN_BLANK_EN to darken the last BLANK_CYCLES of every slot (anti-ghosting).
module seg_scan
  import seg_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int SCAN_FREQ    = 1000,
  parameter int DIGITS       = 6,
  parameter int BLANK_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DIGITS*8-1:0]   seg_data_in,
  output logic [DIGITS-1:0]     seg_sel,
  output logic [7:0]            seg_data,
  output logic                  frame_done
);

  localparam int DIV   = CLK_FREQ / SCAN_FREQ;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  // Reject configurations that cannot produce a meaningful scan.
  if (DIV < 2) begin : g_bad_div
    $error("seg_scan: CLK_FREQ/SCAN_FREQ must be at least 2");
  end
  if (DIGITS < 1) begin : g_bad_digits
    $error("seg_scan: DIGITS must be at least 1");
  end
  if (BLANK_CYCLES >= DIV) begin : g_bad_blank
    $error("seg_scan: BLANK_CYCLES must be smaller than the slot length");
  end

  seg_state_t                   state_q, state_d;
  logic [CNT_W-1:0]             cnt_q,   cnt_d;
  logic [IDX_W-1:0]             idx_q,   idx_d;
  logic [DIGITS-1:0][7:0]       fbuf_q,  fbuf_d;

  logic [DIGITS-1:0]            sel_d;
  logic [7:0]                   data_d;
  logic                         done_d;

  // Next-state logic for the divider, digit index, FSM and frame buffer.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    fbuf_d  = fbuf_q;

    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SHOW;
          cnt_d   = '0;
          idx_d   = '0;
          fbuf_d  = seg_data_in;
        end
        default: begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              // Capture only at frame start so one frame never mixes two inputs.
              idx_d  = '0;
              fbuf_d = seg_data_in;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
`ifdef SEG_SCAN_BLANK_EN
            if (cnt_d == CNT_W'(DIV - BLANK_CYCLES)) begin
              state_d = ST_BLANK;
            end
`endif
          end
        end
      endcase
    end
  end

  // Outputs are derived from the next state so they register on the same edge.
  always_comb begin
    sel_d  = '1;
    data_d = SEG_OFF;
    if (state_d == ST_SHOW) begin
      sel_d[idx_d] = 1'b0;
      data_d       = fbuf_d[idx_d];
    end
    done_d = (state_d != ST_IDLE) && (cnt_d == CNT_LAST) && (idx_d == IDX_LAST);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  // NOTE: the frame buffer is reset so a fresh scan never drives stale or unknown segments.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      fbuf_q     <= {DIGITS{SEG_OFF}};
      seg_sel    <= '1;
      seg_data   <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      fbuf_q     <= fbuf_d;
      seg_sel    <= sel_d;
      seg_data   <= data_d;
      frame_done <= done_d;
    end
  end

endmodule : seg_scan

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan at DIV=10, DIGITS=6, BLANK_CYCLES=2.
// Expected outputs come from a frame-position model pushed into a scoreboard queue.
module tb_seg_scan;

  localparam int DIV    = 10;
  localparam int DIGITS = 6;
  localparam int FRAME  = DIV * DIGITS;
`ifdef SEG_SCAN_BLANK_EN
  localparam int TB_BLANK = 2;
`else
  localparam int TB_BLANK = 0;
`endif

  localparam logic [47:0] D0 = 48'h05_04_03_02_01_00;
  localparam logic [47:0] D1 = 48'hF5_E4_D3_C2_B1_A0;

  typedef struct {
    logic [5:0] sel;
    logic [7:0] data;
    logic       done;
  } exp_t;

  typedef struct {
    string       name;
    logic        rst_v;
    logic        en_v;
    logic [47:0] data_v;
    int          cycles;
    int          exp_pulses;
  } phase_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [47:0] seg_data_in;
  logic [5:0]  seg_sel;
  logic [7:0]  seg_data;
  logic        frame_done;

  int errors = 0;
  int checks = 0;
  int pulse_cnt = 0;
  int cyc = 0;

  exp_t sb_q[$];

  bit          running = 1'b0;
  int          pos = 0;
  logic [47:0] exp_fb = '1;

  seg_scan #(
    .CLK_FREQ    (1000),
    .SCAN_FREQ   (100),
    .DIGITS      (6),
    .BLANK_CYCLES(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .seg_data_in(seg_data_in),
    .seg_sel    (seg_sel),
    .seg_data   (seg_data),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model of the outputs after the coming edge, from position within the frame.
  task automatic model_push(input logic rst_v, input logic en_v, input logic [47:0] data_v);
    exp_t e;
    int   digit;
    int   sub;
    e.sel  = '1;
    e.data = 8'hFF;
    e.done = 1'b0;
    if (rst_v) begin
      running = 1'b0;
      pos     = 0;
      exp_fb  = '1;
    end else if (!en_v) begin
      running = 1'b0;
      pos     = 0;
    end else begin
      if (running) pos++;
      else begin
        running = 1'b1;
        pos     = 0;
      end
      if (pos % FRAME == 0) exp_fb = data_v;
      digit = (pos / DIV) % DIGITS;
      sub   = pos % DIV;
      if (sub < DIV - TB_BLANK) begin
        e.sel[digit] = 1'b0;
        e.data       = exp_fb[digit*8 +: 8];
      end
      e.done = (sub == DIV - 1) && (digit == DIGITS - 1);
    end
    sb_q.push_back(e);
  endtask

  task automatic step(input string tag, input logic rst_v, input logic en_v,
                      input logic [47:0] data_v);
    exp_t e;
    @(negedge clk);
    rst         = rst_v;
    en          = en_v;
    seg_data_in = data_v;
    model_push(rst_v, en_v, data_v);
    @(posedge clk);
    #1;
    cyc++;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty @%0d", tag, cyc);
    end else begin
      e = sb_q.pop_front();
      check($sformatf("%s sel @%0d", tag, cyc),  64'(seg_sel),    64'(e.sel));
      check($sformatf("%s data @%0d", tag, cyc), 64'(seg_data),   64'(e.data));
      check($sformatf("%s done @%0d", tag, cyc), 64'(frame_done), 64'(e.done));
    end
    if (frame_done === 1'b1) pulse_cnt++;
  endtask

  task automatic run(input string tag, input logic rst_v, input logic en_v,
                     input logic [47:0] data_v, input int n);
    for (int i = 0; i < n; i++) step(tag, rst_v, en_v, data_v);
  endtask

  initial begin
    phase_t phases[5];
    int     p0;

    rst         = 1'b1;
    en          = 1'b1;
    seg_data_in = D0;

    phases[0] = '{"rst_hold",   1'b1, 1'b1, D0, 3,   0};
    phases[1] = '{"run_frames", 1'b0, 1'b1, D0, 130, 2};
    phases[2] = '{"en_low",     1'b0, 1'b0, D0, 4,   0};
    phases[3] = '{"run_new",    1'b0, 1'b1, D1, 61,  1};
    phases[4] = '{"rst_mid",    1'b1, 1'b1, D1, 2,   0};

    for (int k = 0; k < 5; k++) begin
      p0 = pulse_cnt;
      run(phases[k].name, phases[k].rst_v, phases[k].en_v, phases[k].data_v, phases[k].cycles);
      check({phases[k].name, " pulses"}, 64'(pulse_cnt - p0), 64'(phases[k].exp_pulses));
    end

    // Input change while digit 2 is shown: old frame finishes, new one starts at digit 0.
    step("restart_a", 1'b0, 1'b0, D0);
    run("midframe_old", 1'b0, 1'b1, D0, 25);
    run("midframe_new", 1'b0, 1'b1, D1, 6);
    check("midframe digit3 old data", 64'(seg_data), 64'h03);
    check("midframe digit3 sel",      64'(seg_sel),  64'(6'b110111));
    run("midframe_new", 1'b0, 1'b1, D1, 30);
    check("newframe digit0 data", 64'(seg_data), 64'hA0);
    check("newframe digit0 sel",  64'(seg_sel),  64'(6'b111110));

    // Drop en during digit 3, then restart from digit 0 with a fresh capture.
    step("restart_b", 1'b0, 1'b0, D1);
    p0 = pulse_cnt;
    run("abort_run", 1'b0, 1'b1, D1, 36);
    step("abort_drop", 1'b0, 1'b0, D1);
    check("abort off sel",  64'(seg_sel),    64'h3F);
    check("abort off done", 64'(frame_done), 64'h0);
    step("abort_idle", 1'b0, 1'b0, D1);
    step("abort_rise", 1'b0, 1'b1, D0);
    check("restart digit0 sel",  64'(seg_sel),  64'(6'b111110));
    check("restart digit0 data", 64'(seg_data), 64'h00);
    run("restart_run", 1'b0, 1'b1, D0, 10);
    check("restart slot1 sel", 64'(seg_sel), 64'(6'b111101));
    check("abort no pulse", 64'(pulse_cnt - p0), 64'h0);

    // Reset lands on the edge that would enter counter 9 of digit 5.
    step("restart_c", 1'b0, 1'b0, D0);
    p0 = pulse_cnt;
    run("pre_rst", 1'b0, 1'b1, D0, 59);
    step("late_rst", 1'b1, 1'b1, D0);
    check("late_rst sel",  64'(seg_sel),    64'h3F);
    check("late_rst data", 64'(seg_data),   64'hFF);
    check("late_rst done", 64'(frame_done), 64'h0);
    check("late_rst no pulse", 64'(pulse_cnt - p0), 64'h0);
    run("post_rst", 1'b0, 1'b1, D1, 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_seg_scan
